// File: rtl/prio_arb_pkg.sv
// Shared definitions for the prio_arb arbiter: FSM state encoding and the
// hold-counter width helper.
package prio_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Smallest width (at least 1) that can represent max_hold-1.
  function automatic int hold_width(input int max_hold);
    int w;
    w = 1;
    while ((1 << w) < max_hold) w++;
    return w;
  endfunction

endpackage

// File: rtl/prio_enc.sv
// Priority encoder: reports the highest set bit of req and whether any bit is set.
module prio_enc #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [(1<<WIDTH_LOG)-1:0] req,
  output logic [WIDTH_LOG-1:0]      idx,
  output logic                      any
);

  localparam int WIDTH = 1 << WIDTH_LOG;

  // Ascending scan, so the last hit (highest index) wins.
  always_comb begin
    idx = '0;
    any = |req;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) idx = WIDTH_LOG'(i);
    end
  end

endmodule

// File: rtl/prio_arb.sv
// Single-grant arbiter with hold timeout. Fixed priority (highest index) by
// default; defining PRIO_ARB_RR_EN switches to downward round-robin.
module prio_arb
  import prio_arb_pkg::*;
#(
  parameter int WIDTH_LOG = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [(1<<WIDTH_LOG)-1:0] req,
  input  logic                      done,
  output logic [(1<<WIDTH_LOG)-1:0] gnt,
  output logic [7:0]                gnt_idx,
  output logic                      gnt_vld,
  output logic                      timeout
);

  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int CNT_W = hold_width(MAX_HOLD);

  state_t               state;
  logic [WIDTH_LOG-1:0] cur_idx;
  logic [WIDTH_LOG-1:0] top_idx;
  logic [WIDTH_LOG-1:0] win_idx;
  logic                 top_any;
  logic [WIDTH-1:0]     win_onehot;
  logic [CNT_W-1:0]     cnt;
  logic                 hold_expired;

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_all (
    .req (req),
    .idx (top_idx),
    .any (top_any)
  );

`ifdef PRIO_ARB_RR_EN
  logic [WIDTH_LOG-1:0] ptr;
  logic [WIDTH_LOG-1:0] low_idx;
  logic [WIDTH-1:0]     low_req;
  logic                 low_any;

  // Only requesters strictly below the last grantee compete first.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
    assign low_req[gi] = req[gi] & (WIDTH_LOG'(gi) < ptr);
  end

  prio_enc #(.WIDTH_LOG(WIDTH_LOG)) u_enc_low (
    .req (low_req),
    .idx (low_idx),
    .any (low_any)
  );

  assign win_idx = low_any ? low_idx : top_idx;
`else
  assign win_idx = top_idx;
`endif

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
    assign win_onehot[gi] = (win_idx == WIDTH_LOG'(gi));
  end

  assign hold_expired = (MAX_HOLD > 0) && (cnt == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      cur_idx <= '0;
`ifdef PRIO_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (top_any) begin
          state   <= GRANT;
          gnt     <= win_onehot;
          gnt_idx <= 8'(win_idx);
          cur_idx <= win_idx;
          gnt_vld <= 1'b1;
          cnt     <= '0;
`ifdef PRIO_ARB_RR_EN
          ptr     <= win_idx;
`endif
        end
      end else begin
        // done and a dropped request take precedence over the hold limit.
        if (done || !req[cur_idx] || hold_expired) begin
          state   <= IDLE;
          gnt     <= '0;
          gnt_vld <= 1'b0;
          timeout <= !done && req[cur_idx];
        end else if (cnt != {CNT_W{1'b1}}) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prio_arb.sv
// Scoreboard bench for prio_arb (WIDTH_LOG=2, MAX_HOLD=4); expectations follow
// PRIO_ARB_RR_EN when it is defined.
module tb_prio_arb;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [7:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  prio_arb #(.WIDTH_LOG(2), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One expected grant: value, index, idle cycles before it (-1 = any),
  // cycles held, and the timeout level seen on its release cycle.
  typedef struct {
    logic [3:0] gnt;
    int         idx;
    int         gap;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic sim_done = 1'b0;
  logic rst_q = 1'b0;

  logic       in_grant = 1'b0;
  logic [3:0] cur_gnt;
  logic [7:0] cur_idx;
  int         cur_len;
  int         cur_gap;
  int         gap = 0;
  exp_t       e;

  task automatic push(input logic [3:0] g, input int idx, input int gp,
                      input int len, input logic tmo);
    exp_t x;
    x.gnt = g; x.idx = idx; x.gap = gp; x.len = len; x.tmo = tmo;
    q.push_back(x);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) rst_q <= rst;

  // Monitor: tracks each grant from rise to release and scores it.
  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_gnt", 32'(gnt), 0);
      check("rst_vld", 32'(gnt_vld), 0);
      check("rst_idx", 32'(gnt_idx), 0);
      check("rst_tmo", 32'(timeout), 0);
    end
    if (gnt_vld && !in_grant) begin
      in_grant = 1'b1;
      cur_gnt  = gnt;
      cur_idx  = gnt_idx;
      cur_len  = 1;
      cur_gap  = gap;
      check("grant_tmo", 32'(timeout), 0);
    end else if (gnt_vld) begin
      cur_len++;
      check("hold_stable", {20'd0, gnt, gnt_idx}, {20'd0, cur_gnt, cur_idx});
      check("hold_tmo", 32'(timeout), 0);
    end else if (in_grant) begin
      in_grant = 1'b0;
      gap = 1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b idx=%0d, no grant expected", cur_gnt, cur_idx);
      end else begin
        e = q.pop_front();
        $display("grant gnt=%b idx=%0d gap=%0d len=%0d timeout=%0b", cur_gnt, cur_idx, cur_gap, cur_len, timeout);
        check("gnt", 32'(cur_gnt), 32'(e.gnt));
        check("gnt_idx", 32'(cur_idx), 32'(e.idx));
        check("hold_len", 32'(cur_len), 32'(e.len));
        check("release_tmo", 32'(timeout), 32'(e.tmo));
        if (e.gap >= 0) check("gap", 32'(cur_gap), 32'(e.gap));
      end
    end else begin
      gap++;
      check("idle_tmo", 32'(timeout), 0);
    end
    if (sim_done) begin
      check("pending_grants", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected completion by 100000");
    $fatal(1);
  end

  initial begin
    // Reset held two cycles with all requests up; first grant right after.
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    push(4'b1000, 3, -1, 2, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    req = 4'b0000;
    cyc(3);

    // Two grants with done after 2 cycles, then 1 cycle.
    push(4'b0100, 2, -1, 2, 1'b0);
`ifdef PRIO_ARB_RR_EN
    push(4'b0001, 0, 1, 1, 1'b0);
`else
    push(4'b0100, 2, 1, 1, 1'b0);
`endif
    req = 4'b0101;
    cyc(2);
    done = 1'b1;
    cyc(1);
    done = 1'b0;
    cyc(1);
    done = 1'b1;
    cyc(1);
    done = 1'b0; req = 4'b0000;
    cyc(2);

    // Hold timeout, then a regrant dropped after one cycle.
    push(4'b0010, 1, -1, 4, 1'b1);
    push(4'b0010, 1, 1, 1, 1'b0);
    req = 4'b0010;
    cyc(6);
    req = 4'b0000;
    cyc(2);

    // done in the last hold cycle is an ordinary release.
    push(4'b1000, 3, -1, 4, 1'b0);
    req = 4'b1000;
    cyc(4);
    done = 1'b1;
    cyc(1);
    done = 1'b0; req = 4'b0000;
    cyc(2);

    // Other request rising is ignored; grantee dropping releases.
    push(4'b0100, 2, -1, 2, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
    req = 4'b0100;
    cyc(1);
    req = 4'b1100;
    cyc(1);
    req = 4'b1000;
    cyc(2);
    req = 4'b0000;
    cyc(3);

    // Reset in the second grant cycle; pointer must restart at 0.
    push(4'b0100, 2, -1, 2, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
    req = 4'b0100;
    cyc(2);
    rst = 1'b1; req = 4'b1111;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    done = 1'b1; req = 4'b0000;
    cyc(1);
    done = 1'b0;
    cyc(2);

    // Rotation from a fresh pointer; done raised while idle is ignored.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
`ifdef PRIO_ARB_RR_EN
    push(4'b1000, 3, -1, 1, 1'b0);
    push(4'b0010, 1, 1, 1, 1'b0);
    push(4'b0001, 0, 1, 1, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
`else
    push(4'b1000, 3, -1, 1, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
    push(4'b1000, 3, 1, 1, 1'b0);
`endif
    req = 4'b1011; done = 1'b1;
    cyc(2);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      done = 1'b1;
      cyc(1);
      done = 1'b0;
    end
    req = 4'b0000;
    cyc(3);

    sim_done = 1'b1;
  end

endmodule

// File: doc/prio_arb.md
PRIO_ARB -- requirements
Module: prio_arb

Interface
REQ-001 SHALL have parameter WIDTH_LOG, default 4: log2 of requester count; WIDTH = 1 << WIDTH_LOG.
REQ-002 SHALL have parameter MAX_HOLD, default 16: maximum grant length in cycles; 0 = unlimited.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req  input  WIDTH  per-requester request level.
REQ-006 SHALL have port done  input  1  current grantee releases the resource this cycle.
REQ-007 SHALL have port gnt  output  WIDTH  one-hot grant, registered.
REQ-008 SHALL have port gnt_idx  output  8  binary index of the granted requester, registered.
REQ-009 SHALL have port gnt_vld  output  1  high while any grant is held, registered.
REQ-010 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no grant) and GRANT (one grant held).
REQ-012 In IDLE with |req = 1, SHALL select a winner and enter GRANT next cycle, driving gnt, gnt_idx and gnt_vld = 1 from that edge (1-cycle latency).
REQ-013 In IDLE with req = 0, SHALL stay in IDLE; gnt = 0, gnt_vld = 0, gnt_idx holds its last value.
REQ-014 Fixed-priority selection SHALL grant the highest set index of req.
REQ-015 In GRANT, gnt and gnt_idx SHALL stay constant, and changes on other req bits SHALL be ignored.
REQ-016 In GRANT, release SHALL occur on done = 1, on req[gnt_idx] = 0, or on hold timeout, whichever comes first.
REQ-017 Release SHALL return the FSM to IDLE next cycle, giving exactly one cycle with gnt = 0 between consecutive grants.
REQ-018 Hold counter SHALL be cleared on GRANT entry and increment each GRANT cycle.
REQ-019 With MAX_HOLD > 0, when the counter equals MAX_HOLD-1 and done = 0 and req[gnt_idx] = 1, the grant SHALL be revoked and timeout pulsed on the following cycle.
REQ-020 done = 1 in the timeout cycle SHALL count as a normal release, with timeout = 0.
REQ-021 done asserted in IDLE SHALL be ignored.
REQ-022 The counter SHALL be wide enough for MAX_HOLD-1 and SHALL never wrap.

Reset
REQ-023 rst = 1 at a clock edge SHALL force IDLE, gnt = 0, gnt_idx = 0, gnt_vld = 0, timeout = 0, counter = 0 and round-robin pointer = 0, overriding any other event that cycle.
REQ-024 Reset mid-grant SHALL drop the grant on that edge without pulsing timeout.
REQ-025 The first arbitration SHALL be possible in the cycle after rst deasserts.

Configuration
REQ-026 Macro PRIO_ARB_RR_EN SHALL select round-robin arbitration when defined.
REQ-027 With PRIO_ARB_RR_EN, the block SHALL store the last granted index and apply a mask keeping only req bits with index below it.
REQ-028 With PRIO_ARB_RR_EN, a nonzero masked request SHALL grant its highest set bit; otherwise the highest set bit of the unmasked req SHALL win (downward rotation with wrap).
REQ-029 Without PRIO_ARB_RR_EN, the block SHALL use fixed priority per REQ-014 and SHALL contain no pointer register.

Structure
REQ-030 A shared package/header SHALL hold the FSM state encodings (IDLE, GRANT) and a clog2-style width helper for the hold counter.
REQ-031 Winner selection SHALL instantiate the existing prio_enc sub-module (WIDTH_LOG passed through) for each of the unmasked and masked request vectors.
REQ-032 The one-hot gnt SHALL be decoded from the selected index.

Verification (WIDTH_LOG = 2, MAX_HOLD = 4)
REQ-033 Reset: rst held for 2 cycles with req = 4'b1111 -> gnt = 0, gnt_vld = 0, gnt_idx = 0 throughout; first grant comes the cycle after release.
REQ-034 Fixed priority: req = 4'b0101, done pulsed after 2 cycles of grant -> gnt = 4'b0100, gnt_idx = 2, then a 1-cycle gap, then gnt = 4'b0100 again.
REQ-035 Round-robin (PRIO_ARB_RR_EN): req = 4'b1011 held, done pulsed each grant -> grant sequence idx 3, 1, 0, 3, with one idle cycle between each.
REQ-036 Timeout: req = 4'b0010 held, done = 0 -> gnt_vld high for exactly 4 cycles, timeout = 1 for one cycle, then a 1-cycle gap, then regrant idx 1.
REQ-037 Simultaneous events: done = 1 in the 4th hold cycle -> timeout stays 0; req[gnt_idx] dropping mid-grant -> release next cycle; req of another index rising mid-grant -> no change to gnt.
REQ-038 Reset mid-grant: rst pulsed in the 2nd grant cycle -> gnt = 0 on the next edge, timeout = 0, RR pointer = 0.
